// File: rtl/ppfifo_pkg.sv
// Shared definitions for the ping-pong FIFO writer and reader sides.
// Holds the FSM encoding, channel constants and the burst-length clamp helper.
package ppfifo_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrite   = 2'd1,
        StDrain   = 2'd2,
        StRelease = 2'd3
    } ppfifo_state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Usable burst length: the programmed size clamped to the physical half depth.
    function automatic logic [15:0] min_size(input logic [15:0] size, input int unsigned depth);
        if ({16'd0, size} < depth) begin
            return size;
        end
        return depth[15:0];
    endfunction

endpackage

// File: rtl/ppfifo_ch_select.sv
// Picks which FIFO half a new burst takes, alternating when both halves are ready.
module ppfifo_ch_select
    import ppfifo_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_wr_ready,
    input  logic       i_take,
    output logic       o_ch
);

    logic r_next;

    always_comb begin
        case (i_wr_ready)
            2'b01:   o_ch = CH0;
            2'b10:   o_ch = CH1;
            default: o_ch = r_next;
        endcase
    end

    // Whichever half is taken, the other is preferred the next time both are ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_next <= CH0;
        end else if (i_take) begin
            r_next <= ~o_ch;
        end
    end

endmodule

// File: rtl/ppfifo_stream_writer.sv
// Converts a valid/ready word stream into activate/strobe bursts on a ping-pong FIFO
// write port; bursts close on size limit, i_s_last or an input-idle timeout.
module ppfifo_stream_writer
    import ppfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic                  i_s_last,
    input  logic [1:0]            i_wr_ready,
    output logic [1:0]            o_wr_activate,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wstrobe,
    input  logic [15:0]           i_wr_fifo_size,
    output logic                  o_busy,
    output logic                  o_burst_done,
    output logic [15:0]           o_burst_len
);

    localparam int unsigned HALF_DEPTH = 32'd1 << ADDR_WIDTH;

    ppfifo_state_e         r_state;
    ppfifo_state_e         w_state_next;
    logic                  r_ch;
    logic [15:0]           r_limit;
    logic [15:0]           r_count;
    logic [31:0]           r_idle;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wstrobe;
    logic [15:0]           r_burst_len;

    logic [15:0]           w_limit;
    logic                  w_ch_sel;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_end_word;
    logic                  w_timeout;

    ppfifo_ch_select u_ch_select (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_ready (i_wr_ready),
        .i_take     (w_start),
        .o_ch       (w_ch_sel)
    );

    always_comb begin
        w_limit    = min_size(i_wr_fifo_size, HALF_DEPTH);
        w_start    = (r_state == StIdle) && i_s_valid && (i_wr_ready != 2'b00)
                     && (w_limit != 16'd0);
        w_accept   = (r_state == StWrite) && i_s_valid;
        w_end_word = w_accept && ((r_count + 16'd1 == r_limit) || i_s_last);
        // Idle timeout only matters once the burst holds data worth handing over.
        w_timeout  = (TIMEOUT_CYCLES != 32'd0) && (r_state == StWrite) && !w_accept
                     && (r_count != 16'd0) && (r_idle + 32'd1 == TIMEOUT_CYCLES);
    end

    always_comb begin
        w_state_next  = r_state;
        o_s_ready     = 1'b0;
        o_wr_activate = 2'b00;
        o_busy        = 1'b1;
        o_burst_done  = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (w_start) begin
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                o_s_ready     = 1'b1;
                o_wr_activate = (r_ch == CH1) ? 2'b10 : 2'b01;
                if (w_end_word || w_timeout) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                o_wr_activate = (r_ch == CH1) ? 2'b10 : 2'b01;
                w_state_next  = StRelease;
            end
            StRelease: begin
                o_burst_done = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_ch        <= CH0;
            r_limit     <= 16'd0;
            r_count     <= 16'd0;
            r_idle      <= 32'd0;
            r_wdata     <= '0;
            r_wstrobe   <= 1'b0;
            r_burst_len <= 16'd0;
        end else begin
            r_state   <= w_state_next;
            r_wstrobe <= w_accept;
            if (w_accept) begin
                r_wdata <= i_s_data;
            end
            if (w_start) begin
                r_ch    <= w_ch_sel;
                r_limit <= w_limit;
                r_count <= 16'd0;
                r_idle  <= 32'd0;
            end else if (w_accept) begin
                r_count <= r_count + 16'd1;
                r_idle  <= 32'd0;
            end else if ((r_state == StWrite) && (r_idle != TIMEOUT_CYCLES)) begin
                r_idle  <= r_idle + 32'd1;
            end
            // Loaded on the way into release so the length is valid alongside the done pulse.
            if (r_state == StDrain) begin
                r_burst_len <= r_count;
            end
        end
    end

    assign o_wdata     = r_wdata;
    assign o_wstrobe   = r_wstrobe;
    assign o_burst_len = r_burst_len;

endmodule

// File: tb/tb_ppfifo_stream_writer.sv
// Directed and randomized bursts checked against a queue-based model of the writer.
module tb_ppfifo_stream_writer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int         TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic [1:0]  wr_ready = 2'b00;
    logic [1:0]  wr_activate;
    logic [7:0]  wdata;
    logic        wstrobe;
    logic [15:0] fifo_size = 16'd16;
    logic        busy;
    logic        burst_done;
    logic [15:0] burst_len;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [1:0]  q_act[$];
    logic [7:0]  q_dat[$];
    logic [15:0] q_len[$];
    int          q_done_cyc[$];
    logic [7:0]  words[$];
    bit          next_half = 1'b0;
    bit          cur_half = 1'b0;

    ppfifo_stream_writer #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_s_valid      (s_valid),
        .o_s_ready      (s_ready),
        .i_s_data       (s_data),
        .i_s_last       (s_last),
        .i_wr_ready     (wr_ready),
        .o_wr_activate  (wr_activate),
        .o_wdata        (wdata),
        .o_wstrobe      (wstrobe),
        .i_wr_fifo_size (fifo_size),
        .o_busy         (busy),
        .o_burst_done   (burst_done),
        .o_burst_len    (burst_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records every write and every released burst.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (wr_activate == 2'b11) chk("inv_act_11", {30'd0, wr_activate}, 0);
            if (wstrobe) begin
                chk("inv_strobe_needs_act", {31'd0, wr_activate != 2'b00}, 1);
                q_act.push_back(wr_activate);
                q_dat.push_back(wdata);
            end
            if (burst_done) begin
                q_len.push_back(burst_len);
                q_done_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        q_act.delete();
        q_dat.delete();
        q_len.delete();
        q_done_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        wr_ready = 2'b00;
        next_half = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_act"}, {30'd0, wr_activate}, 0);
        chk({tag, "_strobe"}, {31'd0, wstrobe}, 0);
        chk({tag, "_wdata"}, {24'd0, wdata}, 0);
        chk({tag, "_sready"}, {31'd0, s_ready}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, burst_done}, 0);
        chk({tag, "_len"}, {16'd0, burst_len}, 0);
    endtask

    // Reference half choice: single ready half wins, otherwise alternate starting at half 0.
    task automatic pick_half(input logic [1:0] rdy, output bit h);
        if (rdy == 2'b01) h = 1'b0;
        else if (rdy == 2'b10) h = 1'b1;
        else h = next_half;
        next_half = ~h;
    endtask

    task automatic push_word(input logic [7:0] d, input bit last, output int acc_cyc);
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        acc_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            if (s_ready) begin
                acc_cyc = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (acc_cyc < 0) chk("push_timeout", 0, 1);
    endtask

    task automatic run_burst(input string tag, input logic [1:0] rdy, input int size,
                             input int n_push, input int last_idx, input bit gaps,
                             input bit seq_data, output int acc_last, output bit by_word);
        int lim;
        int n;
        int a;
        lim = (size < (1 << AW)) ? size : (1 << AW);
        n = n_push;
        if (last_idx >= 0 && last_idx + 1 < n) n = last_idx + 1;
        if (lim < n) n = lim;
        by_word = (n == lim) || (last_idx == n - 1);
        pick_half(rdy, cur_half);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(seq_data ? 8'(i) : 8'($urandom));
        wr_ready = rdy;
        fifo_size = 16'(size);
        acc_last = -1;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            push_word(words[i], i == last_idx, a);
            acc_last = a;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        if (tag.len() == 0) chk("tag_empty", 0, 1);
    endtask

    task automatic verify_burst(input string tag, input int acc_last, input bit by_word);
        int n;
        n = words.size();
        chk({tag, "_sready_after"}, {31'd0, s_ready}, by_word ? 0 : 1);
        for (int i = 0; i < 40 && q_len.size() == 0; i++) @(negedge clk);
        chk({tag, "_done_seen"}, q_len.size(), 1);
        if (!by_word && q_done_cyc.size() > 0)
            chk({tag, "_timeout_cycle"}, q_done_cyc[0], acc_last + TO + 2);
        repeat (2) @(negedge clk);
        chk({tag, "_done_pulses"}, q_len.size(), 1);
        if (q_len.size() > 0) chk({tag, "_len"}, {16'd0, q_len[0]}, n);
        chk({tag, "_nstrobes"}, q_dat.size(), n);
        for (int i = 0; i < n && i < q_dat.size(); i++) begin
            chk({tag, "_data"}, {24'd0, q_dat[i]}, {24'd0, words[i]});
            chk({tag, "_act"}, {30'd0, q_act[i]}, cur_half ? 2 : 1);
        end
        chk({tag, "_idle_act"}, {30'd0, wr_activate}, 0);
        clear_q();
    endtask

    initial begin
        int a;
        bit bw;
        logic [7:0] w;
        logic [1:0] r;

        do_reset();
        check_reset("rst0");

        // Zero-size FIFO never gets activated.
        wr_ready = 2'b01;
        fifo_size = 16'd0;
        s_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("size0_act", {30'd0, wr_activate}, 0);
            chk("size0_sready", {31'd0, s_ready}, 0);
        end
        s_valid = 1'b0;
        @(negedge clk);

        run_burst("seq16", 2'b01, 16, 16, -1, 1'b0, 1'b1, a, bw);
        verify_burst("seq16", a, bw);

        do_reset();
        for (int b = 0; b < 3; b++) begin
            run_burst("alt11", 2'b11, 4, 4, -1, 1'b0, 1'b0, a, bw);
            verify_burst("alt11", a, bw);
        end

        run_burst("last5", 2'b01, 16, 16, 4, 1'b0, 1'b0, a, bw);
        verify_burst("last5", a, bw);

        run_burst("tmo3", 2'b10, 16, 3, -1, 1'b0, 1'b0, a, bw);
        verify_burst("tmo3", a, bw);

        run_burst("clamp", 2'b01, 300, 300, -1, 1'b0, 1'b0, a, bw);
        verify_burst("clamp", a, bw);

        // No half ready: the writer must wait, then grab half 1 once it frees up.
        fifo_size = 16'd2;
        wr_ready = 2'b00;
        w = 8'($urandom);
        words.delete();
        words.push_back(w);
        s_valid = 1'b1;
        s_data = w;
        s_last = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("rdy00_sready", {31'd0, s_ready}, 0);
            chk("rdy00_act", {30'd0, wr_activate}, 0);
        end
        wr_ready = 2'b10;
        pick_half(2'b10, cur_half);
        @(negedge clk);
        chk("rdy10_act", {30'd0, wr_activate}, 2);
        push_word(words[0], 1'b0, a);
        w = 8'($urandom);
        words.push_back(w);
        push_word(w, 1'b0, a);
        s_valid = 1'b0;
        verify_burst("rdy10", a, 1'b1);

        for (int b = 0; b < 8; b++) begin
            r = 2'($urandom_range(1, 3));
            run_burst("rnd", r, int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
                      int'($urandom_range(0, 22)) - 2, 1'b1, 1'b0, a, bw);
            verify_burst("rnd", a, bw);
        end

        // Reset in the middle of a burst.
        wr_ready = 2'b01;
        fifo_size = 16'd16;
        pick_half(2'b01, cur_half);
        for (int i = 0; i < 4; i++) push_word(8'($urandom), 1'b0, a);
        #2;
        chk("rstmid_pre_strobe", {31'd0, wstrobe}, 1);
        chk("rstmid_pre_act", {30'd0, wr_activate}, 1);
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("rstmid_act", {30'd0, wr_activate}, 0);
        chk("rstmid_strobe", {31'd0, wstrobe}, 0);
        next_half = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        repeat (4) @(negedge clk);
        check_reset("rstmid");
        chk("rstmid_discard", q_dat.size(), 0);
        run_burst("post_rst", 2'b11, 4, 4, -1, 1'b0, 1'b0, a, bw);
        verify_burst("post_rst", a, bw);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
